// File: rtl/iterative_divider.sv
// ---------------------------------------------------------------------------
// iterative_divider
//   Unsigned multi-cycle restoring divider: quotient/remainder of
//   dataA / dataB, one trial subtraction per clock. A start/busy/done
//   handshake lets the sequencer issue DIV-class operations.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   start      : request a division (sampled only in IDLE or DONE)
//   dataA      : dividend, captured on the accepting edge
//   dataB      : divisor, captured on the accepting edge
//   busy       : high while a division is running (RUN)
//   done       : one-cycle pulse, results valid (DONE)
//   divByZero  : last accepted divisor was zero
//   quotient   : quotient of the last completed operation
//   remainder  : remainder of the last completed operation
// ---------------------------------------------------------------------------
module iterative_divider #(
    parameter int nrOfBits = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [nrOfBits-1:0] dataA,
    input  logic [nrOfBits-1:0] dataB,
    output logic                busy,
    output logic                done,
    output logic                divByZero,
    output logic [nrOfBits-1:0] quotient,
    output logic [nrOfBits-1:0] remainder
);

    localparam int W  = nrOfBits;
    localparam int CW = $clog2(nrOfBits + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(nrOfBits);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  divisor_q, divisor_d;
    logic [W:0]    prem_q, prem_d;      // partial remainder, one bit wider than operands
    logic [W-1:0]  wq_q, wq_d;          // working quotient; starts as the dividend
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    // {prem, wq} shifted left by one. prem < divisor always holds, so the
    // top bit of this value is zero and the subtraction below cannot wrap.
    logic [W+1:0]  shifted;
    logic [W+1:0]  trial;
    logic          borrow;

    always_comb begin
        shifted = {prem_q, wq_q[W-1]};
        trial   = shifted - {2'b00, divisor_q};
        borrow  = trial[W+1];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        divisor_d   = divisor_q;
        prem_d      = prem_q;
        wq_d        = wq_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_RUN: begin
                prem_d = borrow ? shifted[W:0] : trial[W:0];
                wq_d   = {wq_q[W-2:0], ~borrow};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quotient_d  = wq_d;
                    remainder_d = prem_d[W-1:0];
                    state_d     = S_DONE;
                end
            end
            default: begin  // IDLE or DONE: both can accept a new request
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    if (dataB == '0) begin
                        // Zero divisor resolves immediately without iterating
                        quotient_d  = '1;
                        remainder_d = dataA;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        divisor_d = dataB;
                        wq_d      = dataA;
                        prem_d    = '0;
                        cnt_d     = CNT_LOAD;
                        dbz_d     = 1'b0;
                        state_d   = S_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            wq_q        <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            divisor_q   <= divisor_d;
            prem_q      <= prem_d;
            wq_q        <= wq_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign divByZero = dbz_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dataA;
    logic [N-1:0] dataB;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    int checks   = 0;
    int failures = 0;

    iterative_divider #(.nrOfBits(N)) dut (
        .clock(clock), .reset(reset), .start(start),
        .dataA(dataA), .dataB(dataB),
        .busy(busy), .done(done), .divByZero(divByZero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clock = ~clock;

    // Issue one operation and wait (bounded) for done. Inputs change and
    // outputs are observed on negedges. cycles = negedges after the accepting
    // edge up to and including the done cycle; 40 means timeout.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int cycles, output int busy_cnt);
        @(negedge clock);
        start = 1'b1; dataA = a; dataB = b;
        @(negedge clock);
        start = 1'b0;
        cycles = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dataA = '0; dataB = '0;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (divByZero !== 1'b0) begin failures++; $display("FAIL reset_dbz got %b exp 0", divByZero); end
        checks++; if ({quotient, remainder} !== 16'h0) begin failures++; $display("FAIL reset_qr got %0d,%0d exp 0,0", quotient, remainder); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, bc;
        run_op(8'd100, 8'd7, cyc, bc);
        checks++; if (cyc !== 9) begin failures++; $display("FAIL basic_latency got %0d exp 9", cyc); end
        checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got %0d exp 8", bc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_with_done got %b exp 0", busy); end
        checks++; if (quotient !== 8'd14 || remainder !== 8'd2) begin failures++; $display("FAIL basic_qr got %0d,%0d exp 14,2", quotient, remainder); end
        checks++; if (divByZero !== 1'b0) begin failures++; $display("FAIL basic_dbz got %b exp 0", divByZero); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        checks++; if (quotient !== 8'd14 || remainder !== 8'd2) begin failures++; $display("FAIL basic_hold got %0d,%0d exp 14,2", quotient, remainder); end
    endtask

    task automatic test_values();
        logic [7:0] va [4] = '{8'd255, 8'd5, 8'd200, 8'd255};
        logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd200, 8'd128};
        logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd1,   8'd1};
        logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0,   8'd127};
        int cyc, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], cyc, bc);
            checks++; if (cyc !== 9) begin failures++; $display("FAIL values_latency[%0d] got %0d exp 9", i, cyc); end
            checks++; if (quotient !== eq[i] || remainder !== er[i]) begin
                failures++; $display("FAIL values_qr %0d/%0d got %0d,%0d exp %0d,%0d", va[i], vb[i], quotient, remainder, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        run_op(8'd42, 8'd0, cyc, bc);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL dz_latency got %0d exp 1", cyc); end
        checks++; if (bc !== 0) begin failures++; $display("FAIL dz_busy got %0d exp 0", bc); end
        checks++; if (quotient !== 8'd255 || remainder !== 8'd42) begin failures++; $display("FAIL dz_qr got %0d,%0d exp 255,42", quotient, remainder); end
        checks++; if (divByZero !== 1'b1) begin failures++; $display("FAIL dz_flag got %b exp 1", divByZero); end
        run_op(8'd9, 8'd3, cyc, bc);
        checks++; if (quotient !== 8'd3 || remainder !== 8'd0) begin failures++; $display("FAIL dz_next_qr got %0d,%0d exp 3,0", quotient, remainder); end
        checks++; if (divByZero !== 1'b0) begin failures++; $display("FAIL dz_clear got %b exp 0", divByZero); end
    endtask

    task automatic test_start_ignored();
        int done_cnt = 0, done_cyc = 0;
        logic [N-1:0] q_at = '0, r_at = '0;
        @(negedge clock);
        start = 1'b1; dataA = 8'd100; dataB = 8'd7;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 3) begin start = 1'b1; dataA = 8'd50; dataB = 8'd5; end
            else start = 1'b0;
            if (done) begin done_cnt++; done_cyc = c; q_at = quotient; r_at = remainder; end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_count got %0d exp 1", done_cnt); end
        checks++; if (done_cyc !== 9) begin failures++; $display("FAIL ign_latency got %0d exp 9", done_cyc); end
        checks++; if (q_at !== 8'd14 || r_at !== 8'd2) begin failures++; $display("FAIL ign_qr got %0d,%0d exp 14,2", q_at, r_at); end
    endtask

    task automatic test_reset_mid();
        int late_done = 0, cyc, bc;
        @(negedge clock);
        start = 1'b1; dataA = 8'd100; dataB = 8'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_state got busy=%b done=%b exp 0,0", busy, done); end
        checks++; if ({quotient, remainder, divByZero} !== 17'h0) begin failures++; $display("FAIL rmid_outputs got %0d,%0d,%b exp 0,0,0", quotient, remainder, divByZero); end
        reset = 1'b0;
        repeat (15) begin @(negedge clock); if (done || busy) late_done++; end
        checks++; if (late_done !== 0) begin failures++; $display("FAIL rmid_ghost got %0d exp 0", late_done); end
        run_op(8'd81, 8'd9, cyc, bc);
        checks++; if (cyc !== 9) begin failures++; $display("FAIL rmid_next_latency got %0d exp 9", cyc); end
        checks++; if (quotient !== 8'd9 || remainder !== 8'd0) begin failures++; $display("FAIL rmid_next_qr got %0d,%0d exp 9,0", quotient, remainder); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        @(negedge clock);
        start = 1'b1; dataA = 8'd100; dataB = 8'd7;
        do begin @(negedge clock); cyc++; end while (!done && cyc < 40);
        checks++; if (cyc !== 9) begin failures++; $display("FAIL b2b_first_latency got %0d exp 9", cyc); end
        checks++; if (quotient !== 8'd14 || remainder !== 8'd2) begin failures++; $display("FAIL b2b_first_qr got %0d,%0d exp 14,2", quotient, remainder); end
        dataA = 8'd60; dataB = 8'd6;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_idle got busy=%b exp 1", busy); end
        while (!done && cyc < 40) begin @(negedge clock); cyc++; end
        checks++; if (cyc !== 9) begin failures++; $display("FAIL b2b_second_latency got %0d exp 9", cyc); end
        checks++; if (quotient !== 8'd10 || remainder !== 8'd0) begin failures++; $display("FAIL b2b_second_qr got %0d,%0d exp 10,0", quotient, remainder); end
    endtask

    task automatic test_random();
        int cyc, bc;
        logic [N-1:0] a, b, eq, er;
        logic ed;
        for (int i = 0; i < 2000; i++) begin
            a = N'($urandom_range(0, 255));
            b = (i % 50 == 0) ? '0 : N'($urandom_range(0, 255));
            if (b == '0) begin eq = '1; er = a; ed = 1'b1; end
            else begin eq = a / b; er = a % b; ed = 1'b0; end
            run_op(a, b, cyc, bc);
            checks++; if (cyc !== (ed ? 1 : 9)) begin failures++; $display("FAIL rand_latency %0d/%0d got %0d", a, b, cyc); end
            checks++; if ({quotient, remainder, divByZero} !== {eq, er, ed}) begin
                failures++; $display("FAIL rand_qr %0d/%0d got %0d,%0d,%b exp %0d,%0d,%b", a, b, quotient, remainder, divByZero, eq, er, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
